// File: rtl/ram_arbiter.sv
// Two-port valid/ready arbiter and one-cycle sequencer for the single-port word RAM.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin; otherwise port 0 has fixed priority.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [3:0]            m0_wstrb,
  input  logic [31:0]           m0_wdata,
  output logic [31:0]           m0_rdata,
  output logic                  m0_ready,
  input  logic                  m1_valid,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [3:0]            m1_wstrb,
  input  logic [31:0]           m1_wdata,
  output logic [31:0]           m1_rdata,
  output logic                  m1_ready,
  output logic                  ram_sel,
  output logic [3:0]            ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        grant_q;
  logic        last_grant_q;
  logic        win;
  logic        any_req;
  logic [31:0] rdata_q;

  assign any_req  = m0_valid | m1_valid;
  assign busy     = (state_q != IDLE);
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    win     = last_grant_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (m0_valid && m1_valid)
      win = ~last_grant_q;
    else if (m0_valid)
      win = 1'b0;
    else if (m1_valid)
      win = 1'b1;
`else
    if (m0_valid)
      win = 1'b0;
    else if (m1_valid)
      win = 1'b1;
`endif
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // All RAM-facing lines come from flops; nothing from mX_* reaches them combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ram_sel      <= 1'b0;
      ram_wen      <= 4'b0;
      ram_address  <= '0;
      ram_wdata    <= 32'b0;
      rdata_q      <= 32'b0;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q      <= win;
            last_grant_q <= win;
            ram_sel      <= 1'b1;
            ram_wen      <= win ? m1_wstrb : m0_wstrb;
            ram_address  <= win ? m1_addr  : m0_addr;
            ram_wdata    <= win ? m1_wdata : m0_wdata;
          end
        end
        ACCESS: begin
          rdata_q  <= ram_rdata;
          ram_sel  <= 1'b0;
          ram_wen  <= 4'b0;
          m0_ready <= ~grant_q;
          m1_ready <= grant_q;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural word RAM
// (combinational shifted read, write only for supported strobe patterns).
module tb_ram_arbiter;

  localparam int AW = 12;

  logic          clk;
  logic          resetn;
  logic          m0_valid;
  logic [AW-1:0] m0_addr;
  logic [3:0]    m0_wstrb;
  logic [31:0]   m0_wdata;
  logic [31:0]   m0_rdata;
  logic          m0_ready;
  logic          m1_valid;
  logic [AW-1:0] m1_addr;
  logic [3:0]    m1_wstrb;
  logic [31:0]   m1_wdata;
  logic [31:0]   m1_rdata;
  logic          m1_ready;
  logic          ram_sel;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          busy;

  int checks;
  int failures;

  logic [31:0] mem [0:1023];

  ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0_valid    (m0_valid),
    .m0_addr     (m0_addr),
    .m0_wstrb    (m0_wstrb),
    .m0_wdata    (m0_wdata),
    .m0_rdata    (m0_rdata),
    .m0_ready    (m0_ready),
    .m1_valid    (m1_valid),
    .m1_addr     (m1_addr),
    .m1_wstrb    (m1_wstrb),
    .m1_wdata    (m1_wdata),
    .m1_rdata    (m1_rdata),
    .m1_ready    (m1_ready),
    .ram_sel     (ram_sel),
    .ram_wen     (ram_wen),
    .ram_address (ram_address),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit strb_ok(input logic [3:0] s);
    return s == 4'b0001 || s == 4'b0010 || s == 4'b0100 ||
           s == 4'b1000 || s == 4'b0011 || s == 4'b1100 ||
           s == 4'b1111;
  endfunction

  always_ff @(posedge clk) begin
    if (ram_sel && strb_ok(ram_wen)) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b])
          mem[ram_address[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  logic [31:0] word_q;
  assign word_q    = mem[ram_address[11:2]];
  assign ram_rdata = word_q >> {ram_address[1:0], 3'b000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit p, input bit v, input logic [AW-1:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    if (p) begin
      m1_valid = v; m1_addr = a; m1_wstrb = s; m1_wdata = d;
    end else begin
      m0_valid = v; m0_addr = a; m0_wstrb = s; m0_wdata = d;
    end
  endtask

  // Issue one request from the current cycle 0 and check the full 3-cycle sequence.
  task automatic txn(input string tag, input bit p, input logic [AW-1:0] a,
                     input logic [3:0] s, input logic [31:0] d,
                     input logic [31:0] exp);
    drive(p, 1'b1, a, s, d);
    step();
    chk({tag, ".sel"}, {31'b0, ram_sel}, 32'd1);
    chk({tag, ".wen"}, {28'b0, ram_wen}, {28'b0, s});
    chk({tag, ".addr"}, {20'b0, ram_address}, {20'b0, a});
    chk({tag, ".wdata"}, ram_wdata, d);
    chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
    step();
    chk({tag, ".rdy"}, {31'b0, p ? m1_ready : m0_ready}, 32'd1);
    chk({tag, ".nrdy"}, {31'b0, p ? m0_ready : m1_ready}, 32'd0);
    chk({tag, ".sel0"}, {31'b0, ram_sel}, 32'd0);
    if (s == 4'b0000)
      chk({tag, ".rdata"}, p ? m1_rdata : m0_rdata, exp);
    drive(p, 1'b0, '0, 4'b0, 32'b0);
    step();
    chk({tag, ".idle"}, {31'b0, busy}, 32'd0);
    chk({tag, ".rdyoff"}, {30'b0, m1_ready, m0_ready}, 32'd0);
  endtask

  initial begin
    bit exp_p;
    bit [3:0] order;
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    drive(1'b0, 1'b0, '0, 4'b0, 32'b0);
    drive(1'b1, 1'b0, '0, 4'b0, 32'b0);
    step();
    step();
    chk("rst.sel", {31'b0, ram_sel}, 32'd0);
    chk("rst.wen", {28'b0, ram_wen}, 32'd0);
    chk("rst.addr", {20'b0, ram_address}, 32'd0);
    chk("rst.wdata", ram_wdata, 32'd0);
    chk("rst.rdy", {30'b0, m1_ready, m0_ready}, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.rdata", m0_rdata, 32'd0);
    resetn = 1'b1;
    step();

    txn("w0", 1'b0, 12'h010, 4'b1111, 32'hDEADBEEF, 32'h0);
    txn("r0", 1'b0, 12'h010, 4'b0000, 32'h0, 32'hDEADBEEF);
    txn("wb1", 1'b1, 12'h010, 4'b0001, 32'h00000055, 32'h0);
    txn("rb1", 1'b1, 12'h011, 4'b0000, 32'h0, 32'h00DEADBE);
    txn("rw1", 1'b1, 12'h010, 4'b0000, 32'h0, 32'hDEADBE55);
    txn("w20", 1'b0, 12'h020, 4'b1111, 32'hCAFEF00D, 32'h0);
    txn("w30", 1'b0, 12'h030, 4'b1111, 32'hA5A5A5A5, 32'h0);
    txn("w0110", 1'b0, 12'h030, 4'b0110, 32'hFFFFFFFF, 32'h0);
    txn("r30", 1'b0, 12'h030, 4'b0000, 32'h0, 32'hA5A5A5A5);
    txn("r20p1", 1'b1, 12'h020, 4'b0000, 32'h0, 32'hCAFEF00D);

    // Both ports request together and hold for four transactions.
`ifdef RAM_ARB_ROUND_ROBIN_EN
    order = 4'b1010;
`else
    order = 4'b0000;
`endif
    drive(1'b0, 1'b1, 12'h010, 4'b0000, 32'h0);
    drive(1'b1, 1'b1, 12'h020, 4'b0000, 32'h0);
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k % 3 == 2) begin
        exp_p = order[k / 3];
        chk($sformatf("sim%0d.r0", k / 3), {31'b0, m0_ready}, {31'b0, ~exp_p});
        chk($sformatf("sim%0d.r1", k / 3), {31'b0, m1_ready}, {31'b0, exp_p});
        chk($sformatf("sim%0d.d", k / 3), m0_rdata,
            exp_p ? 32'hCAFEF00D : 32'hDEADBE55);
      end else begin
        chk($sformatf("sim%0d.quiet", k), {30'b0, m1_ready, m0_ready}, 32'd0);
      end
    end
    drive(1'b0, 1'b0, '0, 4'b0, 32'b0);
    drive(1'b1, 1'b0, '0, 4'b0, 32'b0);
    step();
    chk("sim.idle", {31'b0, busy}, 32'd0);

    // Port 1 arrives while port 0 is in ACCESS.
    drive(1'b0, 1'b1, 12'h010, 4'b0000, 32'h0);
    step();
    chk("col.c1sel", {31'b0, ram_sel}, 32'd1);
    chk("col.c1addr", {20'b0, ram_address}, 32'h010);
    drive(1'b1, 1'b1, 12'h020, 4'b0000, 32'h0);
    step();
    chk("col.c2rdy", {30'b0, m1_ready, m0_ready}, 32'b01);
    drive(1'b0, 1'b0, '0, 4'b0, 32'b0);
    step();
    chk("col.c3sel", {31'b0, ram_sel}, 32'd0);
    chk("col.c3busy", {31'b0, busy}, 32'd0);
    step();
    chk("col.c4sel", {31'b0, ram_sel}, 32'd1);
    chk("col.c4addr", {20'b0, ram_address}, 32'h020);
    chk("col.c4rdy", {30'b0, m1_ready, m0_ready}, 32'd0);
    step();
    chk("col.c5rdy", {30'b0, m1_ready, m0_ready}, 32'b10);
    chk("col.c5data", m1_rdata, 32'hCAFEF00D);
    drive(1'b1, 1'b0, '0, 4'b0, 32'b0);
    step();
    chk("col.c6idle", {31'b0, busy}, 32'd0);

    // Reset lands while a write sits in ACCESS.
    drive(1'b0, 1'b1, 12'h020, 4'b1111, 32'h12345678);
    step();
    chk("rab.sel", {31'b0, ram_sel}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rab.sel0", {31'b0, ram_sel}, 32'd0);
    chk("rab.wen0", {28'b0, ram_wen}, 32'd0);
    chk("rab.addr0", {20'b0, ram_address}, 32'd0);
    chk("rab.wdata0", ram_wdata, 32'd0);
    chk("rab.busy0", {31'b0, busy}, 32'd0);
    drive(1'b0, 1'b0, '0, 4'b0, 32'b0);
    step();
    chk("rab.rdy0", {30'b0, m1_ready, m0_ready}, 32'd0);
    resetn = 1'b1;
    step();
    chk("rab.rdy1", {30'b0, m1_ready, m0_ready}, 32'd0);
    txn("rab.r20", 1'b0, 12'h020, 4'b0000, 32'h0, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
